// File: rtl/clock_rate_arbiter.sv
// clock_rate_arbiter: round-robin arbiter for divider rate changes; new half-period
// takes effect only at a high-to-low CLK_OUT boundary so no short pulses appear.
module clock_rate_arbiter #(
    parameter int          WIDTH        = 16,
    parameter int unsigned DEFAULT_HALF = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] HALF0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] HALF1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ERR,
    output logic             BUSY,
    output logic [WIDTH-1:0] HALF_CUR,
    output logic             CLK_OUT
);
    typedef enum logic [1:0] {IDLE, PEND, GRANT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, half_q, half_d, lat_half_q, lat_half_d;
    logic             clk_q, clk_d, lat_id_q, lat_id_d, rr_q, rr_d;
    logic             term, win;
    logic [WIDTH-1:0] sel_half;
    // rr_q holds the id preferred on a tie: the requester not granted most recently
    assign term     = cnt_q >= half_q - WIDTH'(1);
    assign win      = (REQ0 && REQ1) ? rr_q : REQ1;
    assign sel_half = win ? HALF1 : HALF0;
    always_comb begin
        state_d    = state_q;
        lat_half_d = lat_half_q;
        lat_id_d   = lat_id_q;
        rr_d       = rr_q;
        half_d     = half_q;
        cnt_d      = term ? '0 : cnt_q + WIDTH'(1);
        clk_d      = term ? ~clk_q : clk_q;
        case (state_q)
            IDLE: if (REQ0 || REQ1) begin
                lat_id_d   = win;
                lat_half_d = sel_half;
                state_d    = (sel_half == '0) ? GRANT : PEND;
            end
            PEND: if (clk_q && term) begin
                half_d  = lat_half_q;
                state_d = GRANT;
            end
            GRANT: begin
                rr_d    = ~lat_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clk_q      <= 1'b0;
            half_q     <= WIDTH'(DEFAULT_HALF);
            lat_half_q <= '0;
            lat_id_q   <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            half_q     <= half_d;
            lat_half_q <= lat_half_d;
            lat_id_q   <= lat_id_d;
            rr_q       <= rr_d;
        end
    end
    assign GNT0     = (state_q == GRANT) && !lat_id_q;
    assign GNT1     = (state_q == GRANT) && lat_id_q;
    assign ERR      = (state_q == GRANT) && (lat_half_q == '0);
    assign BUSY     = state_q == PEND;
    assign HALF_CUR = half_q;
    assign CLK_OUT  = clk_q;
endmodule

// File: tb/tb_clock_rate_arbiter.sv
// tb_clock_rate_arbiter: table-driven rate requests with a grant scoreboard and
// an independent CLK_OUT level-length monitor.
module tb_clock_rate_arbiter;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [15:0] HALF0 = '0, HALF1 = '0;
    logic        GNT0, GNT1, ERR, BUSY, CLK_OUT;
    logic [15:0] HALF_CUR;

    clock_rate_arbiter #(.WIDTH(16), .DEFAULT_HALF(2)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .HALF0(HALF0), .REQ1(REQ1), .HALF1(HALF1),
        .GNT0(GNT0), .GNT1(GNT1), .ERR(ERR), .BUSY(BUSY), .HALF_CUR(HALF_CUR), .CLK_OUT(CLK_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic r0; logic [15:0] h0; logic r1; logic [15:0] h1; logic first;} vec_t;
    typedef struct {logic id; logic [15:0] half;} exp_t;
    vec_t tbl[8];
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int mhalf = 2, run_half = 2, run_len = 0;
    logic prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for grants plus a model of the expected length of every CLK_OUT level
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            prev = 1'b0; run_len = 0; run_half = 2; mhalf = 2;
        end else begin
            if (GNT0 && GNT1) check("gnt_exclusive", 1, 0);
            if (ERR && !(GNT0 || GNT1)) check("err_outside_grant", 1, 0);
            if (GNT0 || GNT1) begin
                if (q.size() == 0) check("unexpected_gnt", 1, 0);
                else begin
                    e = q.pop_front();
                    check("gnt_id", int'(GNT1), int'(e.id));
                    check("gnt_err", int'(ERR), int'(e.half == 0));
                    if (e.half != 0) mhalf = e.half;
                    check("half_cur", int'(HALF_CUR), mhalf);
                end
            end
            if (CLK_OUT == prev) run_len++;
            else begin
                check("level_len", run_len, run_half);
                prev = CLK_OUT; run_len = 1; run_half = mhalf;
            end
        end
    end

    task automatic do_req(input vec_t v);
        int old, lat, first_lat;
        logic busy_seen;
        exp_t a, b;
        @(negedge CLK); #1;
        old = mhalf;
        a.id = 1'b0; a.half = v.h0;
        b.id = 1'b1; b.half = v.h1;
        if (v.r0 && v.r1) begin
            q.push_back(v.first ? b : a);
            q.push_back(v.first ? a : b);
        end else if (v.r0) q.push_back(a);
        else q.push_back(b);
        REQ0 = v.r0; HALF0 = v.h0; REQ1 = v.r1; HALF1 = v.h1;
        busy_seen = 1'b0; lat = 0; first_lat = 0;
        while ((REQ0 || REQ1) && lat < 300) begin
            @(posedge CLK); #1;
            lat++;
            if (BUSY) busy_seen = 1'b1;
            if ((GNT0 || GNT1) && first_lat == 0) first_lat = lat;
            if (GNT0) REQ0 = 1'b0;
            if (GNT1) REQ1 = 1'b0;
        end
        if (REQ0 || REQ1) begin
            check("grant_timeout", 1, 0);
            REQ0 = 1'b0; REQ1 = 1'b0;
        end
        if ((!v.r0 || v.h0 == 0) && (!v.r1 || v.h1 == 0)) begin
            check("busy_on_zero", int'(busy_seen), 0);
            check("zero_latency_ok", int'(first_lat >= 1 && first_lat <= 2), 1);
        end else if (!(v.r0 && v.r1))
            check("latency_ok", int'(first_lat >= 2 && first_lat <= 2 * old + 2), 1);
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 16'd3, 1'b1, 16'd7, 1'b0};
        tbl[1] = '{1'b1, 16'd5, 1'b0, 16'd0, 1'b0};
        tbl[2] = '{1'b1, 16'd3, 1'b1, 16'd7, 1'b1};
        tbl[3] = '{1'b0, 16'd0, 1'b1, 16'd0, 1'b1};
        tbl[4] = '{1'b1, 16'd4, 1'b1, 16'd4, 1'b0};
        tbl[5] = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1};
        tbl[6] = '{1'b1, 16'd8, 1'b0, 16'd0, 1'b0};
        tbl[7] = '{1'b1, 16'd0, 1'b1, 16'd0, 1'b1};
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_half", int'(HALF_CUR), 2);
        check("rst_clk_out", int'(CLK_OUT), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_gnt", int'({GNT0, GNT1, ERR}), 0);
        repeat (20) @(posedge CLK);
        for (int i = 0; i < 7; i++) do_req(tbl[i]);
        // shrink 8 -> 1 requested two cycles before the end of a high phase
        n = 0;
        while (CLK_OUT !== 1'b0 && n < 40) begin @(posedge CLK); #1; n++; end
        while (CLK_OUT !== 1'b1 && n < 40) begin @(posedge CLK); #1; n++; end
        check("rise_found", int'(n < 40), 1);
        repeat (5) @(posedge CLK);
        do_req('{1'b1, 16'd1, 1'b0, 16'd0, 1'b0});
        repeat (10) @(posedge CLK);
        do_req(tbl[7]);
        // reset while a request is pending discards it
        @(negedge CLK); #1;
        REQ0 = 1'b1; HALF0 = 16'd9;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!BUSY && n < 20);
        check("pend_reached", int'(BUSY), 1);
        RST = 1'b1; REQ0 = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst_pend_gnt0", int'(GNT0), 0);
        check("rst_pend_half", int'(HALF_CUR), 2);
        check("rst_pend_clk_out", int'(CLK_OUT), 0);
        check("rst_pend_busy", int'(BUSY), 0);
        repeat (20) @(posedge CLK);
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
